muldiv_control_unit: RTL and testbench

- Hardwired control sequencer that drives the existing Datapath control ports for the MUL instruction, and optionally DIV.
- Replaces bench-driven control with a synthesizable Moore FSM: fetch (T0–T2), then execute (T3–T6) writing the 64-bit result to HI/LO.
- Sits beside Datapath and takes the IR contents back from it.

---
 rtl/muldiv_control_unit_pkg.sv | 36 +++
 rtl/muldiv_control_unit_if.sv | 35 +++
 rtl/muldiv_control_unit_reg_sel_decode.sv | 11 +
 rtl/muldiv_control_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_control_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_control_unit_pkg.sv
// Shared control-unit definitions for the hardwired sequencer family.
// Contents:
//   state_t  - sequencer states: IDLE, fetch T0..T2, execute T3..T6, HALT
//   strobe_t - the registered datapath strobes that depend only on state
//   opcode constants (IR[31:27]) and ALU op_sel codes
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [4:0] MUL_OPC = 5'b01111;
  localparam logic [4:0] DIV_OPC = 5'b10000;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b10000;
  localparam logic [4:0] ALU_DIV = 5'b10001;

  typedef struct packed {
    logic pc_out;
    logic mar_rd;
    logic inc_pc;
    logic read;
    logic mdr_rd;
    logic mdr_out;
    logic ir_rd;
    logic zhi_rd;
    logic zlo_rd;
    logic zlo_out;
    logic lo_rd;
    logic zhi_out;
    logic hi_rd;
    logic instr_done;
  } strobe_t;

endpackage

// File: rtl/muldiv_control_unit_if.sv
// Control bundle between the sequencer and the Datapath.
//   master : sequencer side (samples run/ir, drives every control strobe)
//   slave  : Datapath side
// Signals: run, ir[31:0] toward the sequencer; R_rd/R_wrt one-hot register
// enables, bus drive selects (*_out), register loads (*_rd), IncPC, Read,
// op_sel[4:0], instr_done, illegal toward the Datapath.
interface muldiv_control_unit_if;
  logic        run;
  logic [31:0] ir;
  logic [15:0] R_rd;
  logic [15:0] R_wrt;
  logic HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd;
  logic        IncPC;
  logic        Read;
  logic [4:0]  op_sel;
  logic        instr_done;
  logic        illegal;

  modport master (
    input  run, ir,
    output R_rd, R_wrt,
    output HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out,
    output MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd,
    output IncPC, Read, op_sel, instr_done, illegal
  );

  modport slave (
    output run, ir,
    input  R_rd, R_wrt,
    input  HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out,
    input  MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd,
    input  IncPC, Read, op_sel, instr_done, illegal
  );
endinterface

// File: rtl/muldiv_control_unit_reg_sel_decode.sv
// reg_sel_decode: 4-to-16 one-hot register select with enable.
//   i_en     - enable; output is all-zero when low
//   i_sel    - register index
//   o_onehot - one-hot select
module reg_sel_decode (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_onehot
);
  assign o_onehot = i_en ? (16'h0001 << i_sel) : 16'h0000;
endmodule

// File: rtl/muldiv_control_unit.sv
// muldiv_control_unit: hardwired Moore sequencer driving the Datapath for MUL
// (and DIV when built with MULDIV_CU_DIV_EN defined).
// Fetch T0..T2, execute T3..T6 writing the 64-bit result to HI/LO.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-high reset
//   bus  - muldiv_control_unit_if.master (run, ir in; all control strobes out)
// Parameter MEM_WAIT (0..15): extra cycles T1 is held for the memory read.
// Optional build macro: MULDIV_CU_DIV_EN enables the DIV opcode.
module muldiv_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic clr,
  muldiv_control_unit_if.master bus
);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  strobe_t     r_stb;
  logic [4:0]  r_op_sel;

  logic [4:0]  w_opc;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_legal;
  logic        w_en_ra;
  logic        w_en_rb;
  logic [15:0] w_rwrt_ra;
  logic [15:0] w_rwrt_rb;
  logic        w_unused_ir;

  assign w_opc    = bus.ir[31:27];
  assign w_is_mul = (w_opc == MUL_OPC);
`ifdef MULDIV_CU_DIV_EN
  assign w_is_div = (w_opc == DIV_OPC);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_legal     = w_is_mul | w_is_div;
  assign w_unused_ir = ^bus.ir[18:0];

  // Strobes that depend only on the state are registered from the next
  // state so they change cleanly with the state register.
  function automatic strobe_t strobes_for(input state_t s);
    strobe_t v;
    v = '0;
    case (s)
      T0: begin v.pc_out = 1'b1; v.mar_rd = 1'b1; v.inc_pc = 1'b1; end
      T1: begin v.read = 1'b1; v.mdr_rd = 1'b1; end
      T2: begin v.mdr_out = 1'b1; v.ir_rd = 1'b1; end
      T4: begin v.zhi_rd = 1'b1; v.zlo_rd = 1'b1; end
      T5: begin v.zlo_out = 1'b1; v.lo_rd = 1'b1; end
      T6: begin v.zhi_out = 1'b1; v.hi_rd = 1'b1; v.instr_done = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.run) w_next = T0;
      T0:      w_next = T1;
      T1:      if (r_cnt == 4'd0) w_next = T2;
      T2:      w_next = T3;
      T3:      w_next = w_legal ? T4 : HALT;
      T4:      w_next = T5;
      T5:      w_next = T6;
      T6:      w_next = bus.run ? T0 : IDLE;
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_stb    <= '0;
      r_op_sel <= ALU_NOP;
    end else begin
      r_state  <= w_next;
      r_stb    <= strobes_for(w_next);
      // IR is already valid in T3, so the T4 ALU code is taken from it here.
      r_op_sel <= (w_next == T4) ? (w_is_div ? ALU_DIV : ALU_MUL) : ALU_NOP;
      // Wait counter loads on T1 entry; T1 is left once it reads zero.
      if (w_next == T1 && r_state != T1)
        r_cnt <= 4'(MEM_WAIT);
      else if (r_state == T1 && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Register-file drivers and Y load depend on IR contents, which are only
  // valid once T3 is reached, so they are decoded from the live state.
  assign w_en_ra = (r_state == T3) && w_legal;
  assign w_en_rb = (r_state == T4);

  reg_sel_decode u_dec_ra (.i_en(w_en_ra), .i_sel(bus.ir[26:23]), .o_onehot(w_rwrt_ra));
  reg_sel_decode u_dec_rb (.i_en(w_en_rb), .i_sel(bus.ir[22:19]), .o_onehot(w_rwrt_rb));

  assign bus.R_rd       = 16'h0000;
  assign bus.R_wrt      = w_rwrt_ra | w_rwrt_rb;
  assign bus.HI_out     = 1'b0;
  assign bus.LO_out     = 1'b0;
  assign bus.Zhi_out    = r_stb.zhi_out;
  assign bus.Zlo_out    = r_stb.zlo_out;
  assign bus.PC_out     = r_stb.pc_out;
  assign bus.MDR_out    = r_stb.mdr_out;
  assign bus.MAR_out    = 1'b0;
  assign bus.In_out     = 1'b0;
  assign bus.C_out      = 1'b0;
  assign bus.MAR_rd     = r_stb.mar_rd;
  assign bus.Zhi_rd     = r_stb.zhi_rd;
  assign bus.Zlo_rd     = r_stb.zlo_rd;
  assign bus.PC_rd      = 1'b0;
  assign bus.MDR_rd     = r_stb.mdr_rd;
  assign bus.IR_rd      = r_stb.ir_rd;
  assign bus.Y_rd       = w_en_ra;
  assign bus.HI_rd      = r_stb.hi_rd;
  assign bus.LO_rd      = r_stb.lo_rd;
  assign bus.IncPC      = r_stb.inc_pc;
  assign bus.Read       = r_stb.read;
  assign bus.op_sel     = r_op_sel;
  assign bus.instr_done = r_stb.instr_done;
  // Flagged already in T3 for an unknown opcode, then held by HALT.
  assign bus.illegal    = (r_state == HALT) || ((r_state == T3) && !w_legal);

endmodule

// File: tb/tb_muldiv_control_unit.sv
// Bench for muldiv_control_unit: two instances (MEM_WAIT 0 and 3) are compared
// every cycle against an offset-based reference of the instruction timeline.
module tb_muldiv_control_unit;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        tb_run [2];
  logic [31:0] tb_ir  [2];

  muldiv_control_unit_if bus0 ();
  muldiv_control_unit_if bus3 ();

  assign bus0.run = tb_run[0];
  assign bus0.ir  = tb_ir[0];
  assign bus3.run = tb_run[1];
  assign bus3.ir  = tb_ir[1];

  muldiv_control_unit #(.MEM_WAIT(0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));
  muldiv_control_unit #(.MEM_WAIT(3)) dut3 (.clk(clk), .clr(clr), .bus(bus3));

  logic [63:0] obs [2];
  assign obs[0] = {5'b0, bus0.R_rd, bus0.R_wrt,
                   bus0.HI_out, bus0.LO_out, bus0.Zhi_out, bus0.Zlo_out, bus0.PC_out,
                   bus0.MDR_out, bus0.MAR_out, bus0.In_out, bus0.C_out,
                   bus0.MAR_rd, bus0.Zhi_rd, bus0.Zlo_rd, bus0.PC_rd, bus0.MDR_rd,
                   bus0.IR_rd, bus0.Y_rd, bus0.HI_rd, bus0.LO_rd,
                   bus0.IncPC, bus0.Read, bus0.op_sel, bus0.instr_done, bus0.illegal};
  assign obs[1] = {5'b0, bus3.R_rd, bus3.R_wrt,
                   bus3.HI_out, bus3.LO_out, bus3.Zhi_out, bus3.Zlo_out, bus3.PC_out,
                   bus3.MDR_out, bus3.MAR_out, bus3.In_out, bus3.C_out,
                   bus3.MAR_rd, bus3.Zhi_rd, bus3.Zlo_rd, bus3.PC_rd, bus3.MDR_rd,
                   bus3.IR_rd, bus3.Y_rd, bus3.HI_rd, bus3.LO_rd,
                   bus3.IncPC, bus3.Read, bus3.op_sel, bus3.instr_done, bus3.illegal};

`ifdef MULDIV_CU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: mode 0 idle, 1 executing (m_off cycles since T0), 2 halted.
  int m_mode [2];
  int m_off  [2];
  int m_w    [2];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, o, e);
    end
  endtask

  function automatic bit legal(input logic [31:0] ir);
    return (ir[31:27] == 5'b01111) || (DIV_EN && ir[31:27] == 5'b10000);
  endfunction

  function automatic logic [63:0] exp_vec(input int mode, input int off, input int w,
                                          input logic [31:0] ir);
    logic [15:0] rwrt;
    logic zhi_out, zlo_out, pc_out, mdr_out;
    logic mar_rd, zhi_rd, zlo_rd, mdr_rd, ir_rd, y_rd, hi_rd, lo_rd;
    logic incpc, rd, done, ill;
    logic [4:0] opsel;
    rwrt = '0; opsel = '0;
    {zhi_out, zlo_out, pc_out, mdr_out} = '0;
    {mar_rd, zhi_rd, zlo_rd, mdr_rd, ir_rd, y_rd, hi_rd, lo_rd} = '0;
    {incpc, rd, done, ill} = '0;
    if (mode == 2) ill = 1'b1;
    else if (mode == 1) begin
      if (off == 0) begin pc_out = 1; mar_rd = 1; incpc = 1; end
      else if (off <= 1 + w) begin rd = 1; mdr_rd = 1; end
      else if (off == 2 + w) begin mdr_out = 1; ir_rd = 1; end
      else if (off == 3 + w) begin
        if (legal(ir)) begin rwrt = 16'h1 << ir[26:23]; y_rd = 1; end
        else ill = 1;
      end
      else if (off == 4 + w) begin
        rwrt = 16'h1 << ir[22:19]; zhi_rd = 1; zlo_rd = 1;
        opsel = (ir[31:27] == 5'b10000) ? 5'b10001 : 5'b10000;
      end
      else if (off == 5 + w) begin zlo_out = 1; lo_rd = 1; end
      else if (off == 6 + w) begin zhi_out = 1; hi_rd = 1; done = 1; end
    end
    return {5'b0, 16'h0, rwrt,
            1'b0, 1'b0, zhi_out, zlo_out, pc_out, mdr_out, 1'b0, 1'b0, 1'b0,
            mar_rd, zhi_rd, zlo_rd, 1'b0, mdr_rd, ir_rd, y_rd, hi_rd, lo_rd,
            incpc, rd, opsel, done, ill};
  endfunction

  task automatic compare_all();
    @(negedge clk);
    cyc++;
    chk("vec_w0", obs[0], exp_vec(m_mode[0], m_off[0], m_w[0], tb_ir[0]));
    chk("vec_w3", obs[1], exp_vec(m_mode[1], m_off[1], m_w[1], tb_ir[1]));
  endtask

  // Advances the reference across the coming clock edge using current inputs.
  task automatic step_all();
    for (int i = 0; i < 2; i++) begin
      case (m_mode[i])
        0: if (tb_run[i]) begin m_mode[i] = 1; m_off[i] = 0; end
        1: begin
          if (m_off[i] == 3 + m_w[i] && !legal(tb_ir[i])) m_mode[i] = 2;
          else if (m_off[i] == 6 + m_w[i]) begin
            if (tb_run[i]) m_off[i] = 0;
            else m_mode[i] = 0;
          end else m_off[i]++;
        end
        default: ;
      endcase
    end
  endtask

  // Called right after a compare: pulses clr between clock edges.
  task automatic pulse_clr(input bit check_now);
    #1 clr = 1'b1;
    #1;
    if (check_now) begin
      chk("clr_async_w0", obs[0], 64'h0);
      chk("clr_async_w3", obs[1], 64'h0);
      chk("clr_opsel", {59'h0, bus0.op_sel}, 64'h0);
    end
    #1 clr = 1'b0;
    for (int i = 0; i < 2; i++) begin m_mode[i] = 0; m_off[i] = 0; end
  endtask

  function automatic logic [31:0] rand_ir();
    int r;
    logic [31:0] v;
    r = $urandom_range(0, 9);
    v = $urandom;
    if (r < 6)      v[31:27] = 5'b01111;
    else if (r < 8) v[31:27] = 5'b10000;
    return v;
  endfunction

  initial begin
    int t0_0, t0_3, last_done0, rd_len, halt_cnt;
    m_w[0] = 0; m_w[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_off[i] = 0; tb_run[i] = 1'b0; tb_ir[i] = 32'h0;
    end
    clr = 1'b1;
    #12;
    chk("rst_w0", obs[0], 64'h0);
    chk("rst_w3", obs[1], 64'h0);
    clr = 1'b0;

    // Back-to-back MUL with run held high.
    compare_all();
    for (int i = 0; i < 2; i++) begin tb_ir[i] = 32'h79300000; tb_run[i] = 1'b1; end
    step_all();
    t0_0 = -1; t0_3 = -1; last_done0 = -1; rd_len = 0;
    for (int k = 0; k < 34; k++) begin
      compare_all();
      if (m_mode[0] == 1 && m_off[0] == 3) chk("ra_onehot", {48'h0, bus0.R_wrt}, 64'h0004);
      if (m_mode[0] == 1 && m_off[0] == 4) begin
        chk("rb_onehot", {48'h0, bus0.R_wrt}, 64'h0040);
        chk("opsel_mul", {59'h0, bus0.op_sel}, 64'h10);
      end
      if (bus0.PC_out) t0_0 = cyc;
      if (bus3.PC_out) t0_3 = cyc;
      if (bus0.instr_done) begin
        chk("done_lat_w0", cyc - t0_0 + 1, 7);
        if (last_done0 >= 0) chk("done_gap_w0", cyc - last_done0, 7);
        last_done0 = cyc;
      end
      if (bus3.instr_done) chk("done_lat_w3", cyc - t0_3 + 1, 10);
      if (bus3.Read) rd_len++;
      else if (rd_len > 0) begin chk("read_len_w3", rd_len, 4); rd_len = 0; end
      // Drop run in T4 near the end; the instruction must still finish.
      if (k > 22)
        for (int i = 0; i < 2; i++)
          if (m_mode[i] == 1 && m_off[i] == 4 + m_w[i]) tb_run[i] = 1'b0;
      step_all();
    end
    chk("idle_after_drop", {62'h0, m_mode[0][1:0]}, 64'h0);

    // Asynchronous clear in the middle of T4.
    compare_all();
    for (int i = 0; i < 2; i++) tb_run[i] = 1'b1;
    step_all();
    for (int k = 0; k < 12; k++) begin
      compare_all();
      if (m_mode[0] == 1 && m_off[0] == 4) begin
        for (int i = 0; i < 2; i++) tb_run[i] = 1'b0;
        pulse_clr(1'b1);
      end
      step_all();
    end

    // Unknown opcode halts until clr.
    compare_all();
    for (int i = 0; i < 2; i++) begin tb_ir[i] = 32'h01234567; tb_run[i] = 1'b1; end
    step_all();
    for (int k = 0; k < 16; k++) begin
      compare_all();
      for (int i = 0; i < 2; i++) tb_run[i] = 1'b0;
      if (m_mode[1] == 2) chk("halt_sticky", {63'h0, bus3.illegal}, 64'h1);
      step_all();
    end
    compare_all();
    pulse_clr(1'b1);
    step_all();

    // DIV opcode: legal only with the optional feature.
    compare_all();
    for (int i = 0; i < 2; i++) begin tb_ir[i] = 32'h81D00000; tb_run[i] = 1'b1; end
    step_all();
    for (int k = 0; k < 14; k++) begin
      compare_all();
      for (int i = 0; i < 2; i++) tb_run[i] = 1'b0;
      if (m_mode[0] == 1 && m_off[0] == 3) chk("div_illegal", {63'h0, bus0.illegal}, {63'h0, !DIV_EN});
      if (m_mode[0] == 1 && m_off[0] == 4) chk("opsel_div", {59'h0, bus0.op_sel}, 64'h11);
      step_all();
    end
    compare_all();
    pulse_clr(1'b0);
    step_all();

    // Randomized run/ir traffic.
    halt_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      compare_all();
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] != 1 || m_off[i] == 0)
          if ($urandom_range(0, 1) == 1) tb_ir[i] = rand_ir();
        tb_run[i] = ($urandom_range(0, 9) < 8);
      end
      if (m_mode[0] == 2 || m_mode[1] == 2) halt_cnt++;
      if (halt_cnt > 4) begin
        halt_cnt = 0;
        pulse_clr(1'b1);
      end
      step_all();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
